// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator-sharing controller.
package acc_pkg;

    typedef enum logic [1:0] {IDLE, STROBE, RECOVER} state_t;

    localparam int ACC_WIDTH = 20;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    // k is the distance from ptr; the first hit in distance order wins.
    always_comb begin
        win = '0;
        idx = '0;
        vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!vld && req[j] && (j == (int'(ptr) + k) % N)) begin
                    vld    = 1'b1;
                    win[j] = 1'b1;
                    idx    = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/acc_share_ctrl.sv
// Round-robin sharing of one accumulator; drives a single clean low add strobe
// per grant and holds it high long enough for the accumulator's edge detector.
module acc_share_ctrl
    import acc_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int WIDTH       = ACC_WIDTH,
    parameter int RECOVER_CYC = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] data_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       done_o,
    output logic                   add_no,
    output logic [WIDTH-1:0]       number_o,
    output logic                   busy_o
);

    localparam int IDX_W = clog2_min1(N_REQ);
    localparam int CNT_W = clog2_min1(RECOVER_CYC);

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              ptr_q, ptr_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [N_REQ-1:0]              win_q, win_d;
    logic [N_REQ-1:0]              gnt_d, done_d;
    logic                          add_d;
    logic [WIDTH-1:0]              num_d;

    logic [N_REQ-1:0][WIDTH-1:0]   data_arr;
    logic [N_REQ-1:0]              pick_win;
    logic [IDX_W-1:0]              pick_idx;
    logic                          pick_vld;

    assign data_arr = data_i;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req_i),
        .ptr (ptr_q),
        .win (pick_win),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    // Every output except busy_o is computed here and registered, so the
    // accumulator only ever sees flop outputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        num_d   = number_o;
        add_d   = 1'b1;
        gnt_d   = '0;
        done_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    num_d   = data_arr[pick_idx];
                    ptr_d   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    win_d   = pick_win;
                    gnt_d   = pick_win;
                    add_d   = 1'b0;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                cnt_d   = CNT_W'(RECOVER_CYC - 1);
                done_d  = win_q;
                state_d = RECOVER;
            end
            RECOVER: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            win_q    <= '0;
            add_no   <= 1'b1;
            gnt_o    <= '0;
            done_o   <= '0;
            number_o <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            add_no   <= add_d;
            gnt_o    <= gnt_d;
            done_o   <= done_d;
            number_o <= num_d;
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_acc_share_ctrl.sv
// Bench for acc_share_ctrl: two configurations checked every cycle against a
// transaction-level schedule model, plus directed scenario checks.
module tb_acc_share_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // u0: N_REQ=4, RECOVER_CYC=1   u1: N_REQ=2, RECOVER_CYC=3
    logic [3:0]        req0 = '0;
    logic [3:0][19:0]  d0   = '0;
    logic [3:0]        gnt0, done0;
    logic              add0, busy0;
    logic [19:0]       num0;

    logic [1:0]        req1 = '0;
    logic [1:0][19:0]  d1   = '0;
    logic [1:0]        gnt1, done1;
    logic              add1, busy1;
    logic [19:0]       num1;

    acc_share_ctrl #(.N_REQ(4), .WIDTH(20), .RECOVER_CYC(1)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .data_i(d0),
        .gnt_o(gnt0), .done_o(done0), .add_no(add0), .number_o(num0), .busy_o(busy0));

    acc_share_ctrl #(.N_REQ(2), .WIDTH(20), .RECOVER_CYC(3)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .data_i(d1),
        .gnt_o(gnt1), .done_o(done1), .add_no(add1), .number_o(num1), .busy_o(busy1));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Accumulators downstream of each controller: add on every low strobe cycle.
    int acc0 = 0;
    int acc1 = 0;
    always @(posedge clk) begin
        if (add0 == 1'b0) acc0 <= acc0 + int'(num0);
        if (add1 == 1'b0) acc1 <= acc1 + int'(num1);
    end

    // Model: each add occupies 1 strobe + RC recover cycles after its arbitration slot.
    int          m_left[2];
    int          m_ptr[2];
    int          m_w[2];
    logic        e_add[2];
    logic        e_busy[2];
    logic [3:0]  e_gnt[2];
    logic [3:0]  e_done[2];
    logic [19:0] e_num[2];

    function automatic int nreq_of(input int i); return (i == 0) ? 4 : 2; endfunction
    function automatic int rc_of(input int i);   return (i == 0) ? 1 : 3; endfunction

    always @(posedge clk or negedge rst_n) begin
        int win, c;
        logic [3:0]  rq;
        logic [19:0] dv;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_left[i] <= 0; m_ptr[i] <= 0; m_w[i] <= 0;
                e_add[i] <= 1'b1; e_busy[i] <= 1'b0;
                e_gnt[i] <= '0; e_done[i] <= '0; e_num[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                e_gnt[i]  <= '0;
                e_done[i] <= '0;
                rq = (i == 0) ? req0 : {2'b00, req1};
                if (m_left[i] == 0) begin
                    win = -1;
                    for (int k = 0; k < nreq_of(i); k++) begin
                        c = (m_ptr[i] + k) % nreq_of(i);
                        if (win < 0 && rq[c]) win = c;
                    end
                    if (win >= 0) begin
                        dv = (i == 0) ? d0[win[1:0]] : d1[win[0]];
                        e_num[i]  <= dv;
                        m_ptr[i]  <= (win + 1) % nreq_of(i);
                        m_w[i]    <= win;
                        e_gnt[i]  <= 4'b0001 << win;
                        e_add[i]  <= 1'b0;
                        e_busy[i] <= 1'b1;
                        m_left[i] <= 1 + rc_of(i);
                    end
                end else begin
                    if (m_left[i] == rc_of(i) + 1) begin
                        e_add[i]  <= 1'b1;
                        e_done[i] <= 4'b0001 << m_w[i];
                    end
                    if (m_left[i] == 1) e_busy[i] <= 1'b0;
                    m_left[i] <= m_left[i] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("u0 add_no",   {31'd0, add0},   {31'd0, e_add[0]});
        chk("u0 gnt_o",    {28'd0, gnt0},   {28'd0, e_gnt[0]});
        chk("u0 done_o",   {28'd0, done0},  {28'd0, e_done[0]});
        chk("u0 number_o", {12'd0, num0},   {12'd0, e_num[0]});
        chk("u0 busy_o",   {31'd0, busy0},  {31'd0, e_busy[0]});
        chk("u1 add_no",   {31'd0, add1},   {31'd0, e_add[1]});
        chk("u1 gnt_o",    {30'd0, gnt1},   {28'd0, e_gnt[1]});
        chk("u1 done_o",   {30'd0, done1},  {28'd0, e_done[1]});
        chk("u1 number_o", {12'd0, num1},   {12'd0, e_num[1]});
        chk("u1 busy_o",   {31'd0, busy1},  {31'd0, e_busy[1]});
    end

    // Strobe log: cycle index (relative to collect start) and grant of each low strobe.
    int         lg_cyc[16];
    logic [3:0] lg_gnt[16];
    int         lg_n;

    task automatic collect(input int inst, input int n, input int maxc);
        int k;
        lg_n = 0;
        k = 0;
        while (lg_n < n && k < maxc) begin
            @(negedge clk);
            k++;
            if (((inst == 0) ? add0 : add1) == 1'b0) begin
                lg_cyc[lg_n] = k;
                lg_gnt[lg_n] = (inst == 0) ? gnt0 : {2'b00, gnt1};
                lg_n++;
            end
        end
        chk("strobe count within budget", lg_n, n);
    endtask

    task automatic do_reset();
        req0 = '0; req1 = '0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int base, bad;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset add_no",   {31'd0, add0},  32'd1);
        chk("reset number_o", {12'd0, num0},  32'd0);
        chk("reset busy_o",   {31'd0, busy0}, 32'd0);
        chk("reset gnt/done", {24'd0, gnt0, done0}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single request, latency and done timing
        base = acc0;
        d0[0] = 20'd5; req0 = 4'b0001;
        @(negedge clk);
        chk("t1 add_no low next cycle", {31'd0, add0}, 32'd0);
        chk("t1 gnt_o",                 {28'd0, gnt0}, 32'h1);
        req0 = '0;
        @(negedge clk);
        chk("t1 done_o",                {28'd0, done0}, 32'h1);
        chk("t1 add_no back high",      {31'd0, add0},  32'd1);
        chk("t1 acc result",            acc0 - base,    32'd5);
        repeat (2) @(negedge clk);

        // 2: two requesters held, alternating grants, period 3
        do_reset();
        base = acc0;
        d0[0] = 20'd3; d0[1] = 20'd7; req0 = 4'b0011;
        collect(0, 4, 40);
        req0 = '0;
        chk("t2 grant 0", {28'd0, lg_gnt[0]}, 32'h1);
        chk("t2 grant 1", {28'd0, lg_gnt[1]}, 32'h2);
        chk("t2 grant 2", {28'd0, lg_gnt[2]}, 32'h1);
        chk("t2 grant 3", {28'd0, lg_gnt[3]}, 32'h2);
        bad = 0;
        for (int k = 1; k < 4; k++) if (lg_cyc[k] - lg_cyc[k-1] != 3) bad++;
        chk("t2 strobe period 3", bad, 0);
        repeat (3) @(negedge clk);
        chk("t2 acc result", acc0 - base, 32'd20);

        // 3: long recovery on u1, lone requester served every slot
        do_reset();
        base = acc1;
        d1[0] = 20'd1; req1 = 2'b01;
        collect(1, 10, 120);
        req1 = '0;
        bad = 0;
        for (int k = 1; k < 10; k++) if (lg_cyc[k] - lg_cyc[k-1] != 5) bad++;
        chk("t3 strobe period 5", bad, 0);
        repeat (6) @(negedge clk);
        chk("t3 acc result", acc1 - base, 32'd10);

        // 4: operand frozen at capture
        do_reset();
        base = acc0;
        d0[0] = 20'd5; req0 = 4'b0001;
        collect(0, 1, 10);
        d0[0] = 20'd9; req0 = '0;
        chk("t4 number_o in strobe", {12'd0, num0}, 32'd5);
        @(negedge clk);
        chk("t4 number_o after", {12'd0, num0}, 32'd5);
        repeat (2) @(negedge clk);
        chk("t4 acc result", acc0 - base, 32'd5);

        // 5: reset during strobe drops the add
        do_reset();
        base = acc0;
        d0[2] = 20'd6; req0 = 4'b0100;
        collect(0, 1, 10);
        req0 = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5 add_no high at once", {31'd0, add0},  32'd1);
        chk("t5 busy_o cleared",      {31'd0, busy0}, 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0 != '0) bad++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done0 != '0) bad++;
        end
        chk("t5 no done for lost add", bad, 0);
        chk("t5 acc unchanged", acc0 - base, 32'd0);
        d0[2] = 20'd4; req0 = 4'b0100;
        collect(0, 1, 10);
        req0 = '0;
        chk("t5 served after reset", {28'd0, lg_gnt[0]}, 32'h4);
        repeat (3) @(negedge clk);
        chk("t5 acc after reset", acc0 - base, 32'd4);

        // 6: N_REQ=4, req 1010 with ptr at 2
        do_reset();
        d0[1] = 20'd2; d0[3] = 20'd8; req0 = 4'b0010;
        collect(0, 1, 10);
        req0 = '0;
        repeat (2) @(negedge clk);
        req0 = 4'b1010;
        collect(0, 3, 30);
        req0 = '0;
        chk("t6 grant 0", {28'd0, lg_gnt[0]}, 32'h8);
        chk("t6 grant 1", {28'd0, lg_gnt[1]}, 32'h2);
        chk("t6 grant 2", {28'd0, lg_gnt[2]}, 32'h8);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
